// File: rtl/cim_pkg.sv
// Shared definitions for the CIM command sequencer: op codes, address
// field positions and the sequencer state encoding.
package cim_pkg;
  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CAM = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int BANK_MSB = 8;
  localparam int BANK_LSB = 5;
  localparam int COL_MSB  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAM_HOLD,
    S_BUBBLE
  } seq_state_e;

  // MAC and CAM both read the array, so both must wait for a prior write
  // to the same bank.
  function automatic logic is_array_rd(input logic [1:0] op);
    return (op == OP_MAC) || (op == OP_CAM);
  endfunction
endpackage

// File: rtl/cim_cmd_fifo.sv
// Small synchronous FIFO holding packed host commands. The pointers carry one
// extra wrap bit so that full and empty can be told apart without a counter.
module cim_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; entries need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cim_cmd_seq.sv
// Command sequencer in front of array_ctrl. Buffers host commands and issues
// one per array slot on registered outputs, holding CAM searches for CAM_CYC
// cycles and inserting a one-cycle bubble between a write and a read of the
// same bank.
module cim_cmd_seq
  import cim_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int CAM_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_bank,
  input  logic [DATA_W-1:0] cmd_in,
  output logic [1:0]        arr_op,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_bank,
  output logic [DATA_W-1:0] arr_in,
  output logic              busy,
  output logic [15:0]       issue_cnt
);
  localparam int EW = 2 + ADDR_W + 2 * DATA_W;
  localparam int CW = (CAM_CYC > 2) ? $clog2(CAM_CYC) : 1;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bank_q, bank_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              lw_vld_q, lw_vld_d;
  logic [BANK_MSB-BANK_LSB:0] lw_bank_q, lw_bank_d;
  logic [15:0]       icnt_q, icnt_d;

  logic              fifo_full, fifo_empty, pop, slot_free, bubble;
  logic [EW-1:0]     head;
  logic [1:0]        h_op;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_bank, h_in;

  cim_cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && !fifo_full),
    .pop   (pop),
    .din   ({cmd_op, cmd_addr, cmd_bank, cmd_in}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign {h_op, h_addr, h_bank, h_in} = head;
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign arr_op    = op_q;
  assign arr_addr  = addr_q;
  assign arr_bank  = bank_q;
  assign arr_in    = in_q;
  assign issue_cnt = icnt_q;

  // Only a write shown in the immediately preceding slot can force a bubble.
  assign bubble = lw_vld_q && is_array_rd(h_op) &&
                  (h_addr[BANK_MSB:BANK_LSB] == lw_bank_q);

  // Next state: decide whether the current slot ends, then fill the next one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    in_d      = in_q;
    lw_vld_d  = lw_vld_q;
    lw_bank_d = lw_bank_q;
    icnt_d    = icnt_q;
    pop       = 1'b0;
    slot_free = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (op_q == OP_CAM && CAM_CYC > 1) begin
          state_d = S_CAM_HOLD;
          cnt_d   = CW'(CAM_CYC - 2);
        end else begin
          slot_free = 1'b1;
        end
      end
      S_CAM_HOLD: begin
        if (cnt_q == '0) slot_free = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: slot_free = 1'b1;
    endcase
    if (slot_free) begin
      lw_vld_d = 1'b0;
      if (fifo_empty) begin
        state_d = S_IDLE;
        op_d    = OP_NOP;
      end else if (bubble) begin
        state_d = S_BUBBLE;
        op_d    = OP_NOP;
      end else begin
        pop       = 1'b1;
        state_d   = S_ISSUE;
        op_d      = h_op;
        addr_d    = h_addr;
        bank_d    = h_bank;
        in_d      = h_in;
        lw_vld_d  = (h_op == OP_WR);
        lw_bank_d = h_addr[BANK_MSB:BANK_LSB];
        if (h_op != OP_NOP) icnt_d = icnt_q + 16'd1;
      end
    end
  end

  // State, hold counter, last-write tracking and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      bank_q    <= '0;
      in_q      <= '0;
      lw_vld_q  <= 1'b0;
      lw_bank_q <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      in_q      <= in_d;
      lw_vld_q  <= lw_vld_d;
      lw_bank_q <= lw_bank_d;
      icnt_q    <= icnt_d;
    end
  end
endmodule
